// File: rtl/opl3_status_if.sv
// Host-side front end for the OPL3 software sequencer: forwards every host write as a one-cycle
// strobe and emulates the OPL3 status port (two timers, overflow flags, IRQ) locally.
module opl3_status_if #(
  parameter int unsigned CLK_HZ = 21477270
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_dout,
  output logic       irq,
  output logic [1:0] opl_addr,
  output logic [7:0] opl_din,
  output logic       opl_wr
);

  localparam int unsigned PRESCALE = CLK_HZ / 12500;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]    idx_q;
  logic          bank_q;
  logic [7:0]    pre1_q, pre2_q;
  logic [7:0]    cnt1_q, cnt2_q, cnt1_d, cnt2_d;
  logic          mask1_q, mask2_q, mask1_d, mask2_d;
  logic          st1_q, st2_q, st1_d, st2_d;
  logic          ft1_q, ft2_q, ft1_d, ft2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    div_q;

  logic tick80, tick320;
  logic idx_wr, dat_wr, ctl_wr, clr_wr, ctl_set;

  assign tick80  = (presc_q == '0);
  assign tick320 = tick80 && (div_q == 2'd0);

  // Data writes only decode against bank 0; bank 1 is forwarded untouched.
  assign idx_wr  = io_wr && !io_addr[0];
  assign dat_wr  = io_wr && io_addr[0] && !bank_q;
  assign ctl_wr  = dat_wr && (idx_q == 8'h04);
  assign clr_wr  = ctl_wr && io_din[7];
  assign ctl_set = ctl_wr && !io_din[7];

  assign irq = ft1_q | ft2_q;

  always_comb begin
    presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;

    mask1_d = ctl_set ? io_din[6] : mask1_q;
    mask2_d = ctl_set ? io_din[5] : mask2_q;
    st1_d   = ctl_set ? io_din[0] : st1_q;
    st2_d   = ctl_set ? io_din[1] : st2_q;

    // Start beats a coincident tick; a stop in the same cycle suppresses the overflow.
    cnt1_d = cnt1_q;
    ft1_d  = ft1_q;
    if (!st1_q && st1_d) begin
      cnt1_d = pre1_q;
    end else if (st1_q && st1_d && tick80) begin
      if (cnt1_q == 8'hFF) begin
        cnt1_d = pre1_q;
        if (!mask1_d) ft1_d = 1'b1;
      end else begin
        cnt1_d = cnt1_q + 8'd1;
      end
    end

    cnt2_d = cnt2_q;
    ft2_d  = ft2_q;
    if (!st2_q && st2_d) begin
      cnt2_d = pre2_q;
    end else if (st2_q && st2_d && tick320) begin
      if (cnt2_q == 8'hFF) begin
        cnt2_d = pre2_q;
        if (!mask2_d) ft2_d = 1'b1;
      end else begin
        cnt2_d = cnt2_q + 8'd1;
      end
    end

    if (clr_wr) begin
      ft1_d = 1'b0;
      ft2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= 8'h00;
      bank_q   <= 1'b0;
      pre1_q   <= 8'h00;
      pre2_q   <= 8'h00;
      cnt1_q   <= 8'h00;
      cnt2_q   <= 8'h00;
      mask1_q  <= 1'b0;
      mask2_q  <= 1'b0;
      st1_q    <= 1'b0;
      st2_q    <= 1'b0;
      ft1_q    <= 1'b0;
      ft2_q    <= 1'b0;
      presc_q  <= '0;
      div_q    <= 2'd0;
      io_dout  <= 8'h00;
      opl_addr <= 2'd0;
      opl_din  <= 8'h00;
      opl_wr   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      if (tick80) div_q <= div_q + 2'd1;

      opl_wr <= io_wr;
      if (io_wr) begin
        opl_addr <= io_addr;
        opl_din  <= io_din;
      end

      if (idx_wr) begin
        idx_q  <= io_din;
        bank_q <= io_addr[1];
      end
      if (dat_wr && (idx_q == 8'h02)) pre1_q <= io_din;
      if (dat_wr && (idx_q == 8'h03)) pre2_q <= io_din;

      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      ft1_q   <= ft1_d;
      ft2_q   <= ft2_d;

      // Snapshot uses the flags as they were before this edge.
      if (io_rd) begin
        io_dout <= (io_addr == 2'b00) ? {ft1_q | ft2_q, ft1_q, ft2_q, 5'b00000} : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_opl3_status_if.sv
// Randomized and directed bench for opl3_status_if against a remaining-ticks timer model.
module tb_opl3_status_if;

  localparam int unsigned CLK_HZ = 125000;
  localparam int          P      = CLK_HZ / 12500;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] io_addr = 2'd0;
  logic [7:0] io_din = 8'h00;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [7:0] io_dout;
  logic       irq;
  logic [1:0] opl_addr;
  logic [7:0] opl_din;
  logic       opl_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opl3_status_if #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_dout  (io_dout),
    .irq      (irq),
    .opl_addr (opl_addr),
    .opl_din  (opl_din),
    .opl_wr   (opl_wr)
  );

  // Model state: timers index 0 = T1, 1 = T2; m_rem counts ticks left until overflow.
  logic [7:0] m_idx, m_dout, m_opl_din;
  logic       m_bank, m_opl_wr;
  logic [1:0] m_opl_addr;
  logic [7:0] m_pre [2];
  logic       m_mask [2], m_st [2], m_ft [2];
  int         m_rem [2];
  int         m_k;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic rd, input logic [1:0] a,
                            input logic [7:0] d);
    logic tick [2];
    logic new_st [2], new_mask [2];
    logic clr;
    if (r) begin
      m_idx = 0; m_bank = 0; m_dout = 0; m_opl_wr = 0; m_opl_addr = 0; m_opl_din = 0; m_k = 0;
      for (int n = 0; n < 2; n++) begin
        m_pre[n] = 0; m_mask[n] = 0; m_st[n] = 0; m_ft[n] = 0; m_rem[n] = 0;
      end
      return;
    end
    tick[0] = (m_k % P) == 0;
    tick[1] = (m_k % (4 * P)) == 0;
    m_k++;
    if (rd) m_dout = (a == 2'b00) ? {m_ft[0] | m_ft[1], m_ft[0], m_ft[1], 5'b0} : 8'hFF;
    m_opl_wr = w;
    if (w) begin
      m_opl_addr = a;
      m_opl_din  = d;
    end
    new_st = m_st;
    new_mask = m_mask;
    clr = 0;
    if (w && a[0] && !m_bank && m_idx == 8'h04) begin
      if (d[7]) clr = 1;
      else begin
        new_mask[0] = d[6]; new_mask[1] = d[5]; new_st[0] = d[0]; new_st[1] = d[1];
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (!m_st[n] && new_st[n]) m_rem[n] = 256 - int'(m_pre[n]);
      else if (m_st[n] && new_st[n] && tick[n]) begin
        m_rem[n]--;
        if (m_rem[n] == 0) begin
          m_rem[n] = 256 - int'(m_pre[n]);
          if (!new_mask[n]) m_ft[n] = 1;
        end
      end
      if (clr) m_ft[n] = 0;
    end
    m_st = new_st;
    m_mask = new_mask;
    if (w && a[0] && !m_bank && m_idx == 8'h02) m_pre[0] = d;
    if (w && a[0] && !m_bank && m_idx == 8'h03) m_pre[1] = d;
    if (w && !a[0]) begin
      m_idx  = d;
      m_bank = a[1];
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [1:0] a,
                      input logic [7:0] d);
    reset = r; io_wr = w; io_rd = rd; io_addr = a; io_din = d;
    model_step(r, w, rd, a, d);
    @(posedge clk);
    #1;
    reset = 0; io_wr = 0; io_rd = 0;
    check_val("irq", {7'b0, irq}, {7'b0, m_ft[0] | m_ft[1]});
    check_val("opl_wr", {7'b0, opl_wr}, {7'b0, m_opl_wr});
    check_val("opl_addr", {6'b0, opl_addr}, {6'b0, m_opl_addr});
    check_val("opl_din", opl_din, m_opl_din);
    check_val("io_dout", io_dout, m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(0, 1, 0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(0, 0, 1, a, 8'h00);
  endtask

  task automatic reg_wr(input logic [7:0] idx, input logic [7:0] d);
    wr(2'd0, idx);
    wr(2'd1, d);
  endtask

  task automatic wait_irq(input int max, input string tag);
    int i = 0;
    while (irq !== 1'b1 && i < max) begin
      idle(1);
      i++;
    end
    check_val(tag, {7'b0, irq}, 8'h01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int r;
    logic [1:0] a;
    logic [7:0] d;

    step(1, 0, 0, 2'd0, 8'h00);
    step(1, 0, 0, 2'd0, 8'h00);
    check_val("reset_dout", io_dout, 8'h00);
    check_val("reset_irq", {7'b0, irq}, 8'h00);

    // Forwarding, single then back-to-back.
    wr(2'd1, 8'h5A);
    check_val("fwd_wr", {7'b0, opl_wr}, 8'h01);
    check_val("fwd_addr", {6'b0, opl_addr}, 8'h01);
    check_val("fwd_din", opl_din, 8'h5A);
    idle(1);
    check_val("fwd_wr_drop", {7'b0, opl_wr}, 8'h00);
    wr(2'd0, 8'h11);
    check_val("b2b_din0", opl_din, 8'h11);
    wr(2'd1, 8'h22);
    check_val("b2b_wr1", {7'b0, opl_wr}, 8'h01);
    check_val("b2b_din1", opl_din, 8'h22);

    // Timer 1 overflow.
    reg_wr(8'h02, 8'hFE);
    reg_wr(8'h04, 8'h01);
    wait_irq(40, "t1_irq");
    rd(2'd0);
    check_val("t1_status", io_dout, 8'hC0);
    idle(60);

    // Timer 2 with mask, then unmasked.
    reg_wr(8'h04, 8'h80);
    reg_wr(8'h03, 8'hFF);
    reg_wr(8'h04, 8'h22);
    idle(8 * 4 * P);
    check_val("t2_masked_irq", {7'b0, irq}, 8'h00);
    wr(2'd1, 8'h02);
    wait_irq(4 * 4 * P + 2, "t2_irq");
    rd(2'd0);
    check_val("t2_status", io_dout, 8'hA0);

    // Flag clear, then clear coincident with an overflow.
    reg_wr(8'h04, 8'h01);
    wait_irq(40, "clr_setup_irq");
    wr(2'd1, 8'h80);
    check_val("clr_irq", {7'b0, irq}, 8'h00);
    rd(2'd0);
    check_val("clr_status", io_dout, 8'h00);
    i = 0;
    while (!(m_st[0] && m_rem[0] == 1 && (m_k % P) == 0) && i < 2000) begin
      idle(1);
      i++;
    end
    check_val("coinc_found", {7'b0, i < 2000}, 8'h01);
    wr(2'd1, 8'h80);
    check_val("coinc_irq", {7'b0, irq}, 8'h00);
    rd(2'd0);
    check_val("coinc_status", io_dout, 8'h00);

    // Bank 1 isolation.
    reg_wr(8'h04, 8'h00);
    wr(2'd1, 8'h80);
    wr(2'd2, 8'h04);
    wr(2'd3, 8'h03);
    check_val("bank1_fwd_addr", {6'b0, opl_addr}, 8'h03);
    check_val("bank1_fwd_din", opl_din, 8'h03);
    idle(400);
    rd(2'd0);
    check_val("bank1_status", io_dout, 8'h00);

    // Reset mid-run; the write in the reset cycle must not be forwarded.
    reg_wr(8'h02, 8'hF0);
    reg_wr(8'h03, 8'hF0);
    reg_wr(8'h04, 8'h03);
    wait_irq(400, "rst_setup_irq");
    step(1, 1, 0, 2'd1, 8'h77);
    check_val("rst_irq", {7'b0, irq}, 8'h00);
    check_val("rst_opl_wr", {7'b0, opl_wr}, 8'h00);
    rd(2'd0);
    check_val("rst_status", io_dout, 8'h00);
    idle(3000);
    check_val("rst_quiet_irq", {7'b0, irq}, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 5000; n++) begin
      r = $urandom_range(0, 999);
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) a[1] = 1'b0;
      d = 8'($urandom_range(0, 255));
      if (!a[0]) begin
        case ($urandom_range(0, 3))
          0: d = 8'h02;
          1: d = 8'h03;
          2: d = 8'h04;
          default: ;
        endcase
      end
      if (r < 3) step(1, 0, 0, a, d);
      else if (r < 200) step(0, 1, $urandom_range(0, 4) == 0, a, d);
      else if (r < 350) step(0, 0, 1, a, d);
      else idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
